pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised inter-stage register for the 5-stage MIPS pipeline (D/E, E/M, M/W).
//  Replaces per-stage hand-written registers: one payload bus plus PC and destination (A3) fields,
//  valid/ready handshake, stall and flush. Inserts bubbles and kills writeback of invalid slots.
// PARAMETERS
//  WIDTH     32            payload width (Instr, AluOut, DMOut, imm, HI, LO packed by caller)
//  PC_W      32            PC field width
//  A3_W      5             destination-register field width
//  PC_RESET  32'h0000_3000 value loaded into out_pc on reset
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  stall      in   1      hold this stage; acts as out_ready=0
//  flush      in   1      synchronous kill of all held entries
//  in_valid   in   1      upstream has a slot
//  in_ready   out  1      stage accepts a slot this cycle
//  in_data    in   WIDTH  payload
//  in_pc      in   PC_W   PC of the slot
//  in_a3      in   A3_W   destination register of the slot
//  out_valid  out  1      slot presented downstream
//  out_ready  in   1      downstream accepts
//  out_data   out  WIDTH  payload
//  out_pc     out  PC_W   PC
//  out_a3     out  A3_W   destination; forced 0 when out_valid=0
//  occ        out  2      entries held (0..2)
// BEHAVIOUR
//  - Reset (reset=0, async): out_valid=0, out_data=0, out_pc=PC_RESET, out_a3=0, occ=0,
//    skid entry invalid; in_ready=1 from first edge after release.
//  - Accept = in_valid & in_ready; Drain = out_valid & out_ready & ~stall.
//  - Latency: accepted slot appears on out_* the next cycle (1 cycle) when the stage is empty.
//  - Main entry holds payload/pc/a3 unchanged while out_valid & ~Drain (no data change under stall).
//  - Accept & Drain same cycle: main entry replaced by new slot, occ unchanged.
//  - out_a3 = a3 & {A3_W{out_valid}}: bubbles never write the GPR or feed forwarding.
//  - out_data/out_pc keep last value when invalid (only out_a3 masked).
//  - flush: next edge clears main and skid valid, occ=0; an Accept in the same cycle is dropped;
//    flush overrides stall; payload registers not cleared. in_ready=1 the cycle after flush.
//  - stall & ~flush: no Drain; Accept still allowed while space remains.
//  - occ never exceeds 2; Accept when full is impossible (in_ready=0).
//  - Reset mid-operation discards all entries immediately (async), no slot emerges.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined: 2-entry skid buffer. in_ready is a register = ~skid_valid
//    (no combinational path out_ready/stall -> in_ready). Accept while main valid and no Drain
//    fills skid (occ=2). On Drain, skid moves to main in order; in_ready rises next cycle.
//    Full throughput with registered ready; slot order strictly FIFO.
//  PIPE_STAGE_SKID_EN undefined: single entry, no skid logic. in_ready = ~out_valid | Drain
//    (combinational); occ in {0,1}; occ[1] tied 0.
// TESTING
//  1 Reset: hold reset=0, then release -> out_valid=0, out_pc=0x3000, out_a3=0, occ=0, in_ready=1.
//  2 Stream: in_valid=1, in_data=0x1..0x8, in_a3=5'd8, out_ready=1 -> out_data=0x1..0x8 one cycle
//    later, one per cycle, no gaps; occ=1 throughout.
//  3 Stall: slot data=0xDEAD_BEEF, a3=31, stall=1 for 3 cycles -> out_data/out_a3 held, occ stays 1,
//    slot emerges exactly once after stall drops; (SKID_EN) next slot 0xCAFE captured, occ=2, in_ready=0.
//  4 Flush with concurrent accept: occ=2, flush=1, in_valid=1 data=0x55 -> next cycle out_valid=0,
//    out_a3=0, occ=0; 0x55 never appears downstream.
//  5 Bubble: in_valid=0 one cycle mid-stream -> exactly one out_valid=0 cycle with out_a3=0.
//  6 Async reset mid-stream: drop reset between edges with occ=2 -> outputs reset immediately;
//    no pre-reset slot emerges after release.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake, stall, flush and bubble masking.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int PC_W = 32,
  parameter int A3_W = 5,
  parameter logic [PC_W-1:0] PC_RESET = PC_W'(32'h0000_3000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [A3_W-1:0]  in_a3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [PC_W-1:0]  out_pc,
  output logic [A3_W-1:0]  out_a3,
  output logic [1:0]       occ
);
  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic [PC_W-1:0]  main_pc;
  logic [A3_W-1:0]  main_a3;
  logic             drain;
  logic             accept;
  assign drain     = main_valid & out_ready & ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_pc    = main_pc;
  // bubbles must never write the register file or feed forwarding
  assign out_a3    = main_a3 & {A3_W{main_valid}};
`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid;
  logic             rdy;
  logic [WIDTH-1:0] skid_data;
  logic [PC_W-1:0]  skid_pc;
  logic [A3_W-1:0]  skid_a3;
  logic             to_skid;
  logic             main_valid_n;
  logic             skid_valid_n;
  assign in_ready     = rdy;
  assign to_skid      = accept & main_valid & ~drain & ~skid_valid;
  assign main_valid_n = ~flush & (skid_valid | accept | (main_valid & ~drain));
  assign skid_valid_n = ~flush & (skid_valid ? ~drain : to_skid);
  assign occ          = {skid_valid, main_valid & ~skid_valid};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      rdy        <= 1'b0;
      main_data  <= '0;
      main_pc    <= PC_RESET;
      main_a3    <= '0;
      skid_data  <= '0;
      skid_pc    <= '0;
      skid_a3    <= '0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      rdy        <= ~skid_valid_n;
      if (!flush && drain && skid_valid) begin
        main_data <= skid_data;
        main_pc   <= skid_pc;
        main_a3   <= skid_a3;
      end else if (!flush && accept && (!main_valid || drain)) begin
        main_data <= in_data;
        main_pc   <= in_pc;
        main_a3   <= in_a3;
      end
      if (!flush && to_skid) begin
        skid_data <= in_data;
        skid_pc   <= in_pc;
        skid_a3   <= in_a3;
      end
    end
  end
`else
  assign in_ready = ~main_valid | drain;
  assign occ      = {1'b0, main_valid};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_pc    <= PC_RESET;
      main_a3    <= '0;
    end else begin
      main_valid <= ~flush & (accept | (main_valid & ~drain));
      if (!flush && accept) begin
        main_data <= in_data;
        main_pc   <= in_pc;
        main_a3   <= in_a3;
      end
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed table, corner sequences and random traffic against a queue-based model.
module tb_pipe_stage_reg;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] in_data = '0, in_pc = '0, out_data, out_pc;
  logic [4:0] in_a3 = '0, out_a3;
  logic [1:0] occ;
  int checks = 0, errors = 0, dead_cnt = 0;
  bit last_acc, rdy_m;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  typedef struct {logic [31:0] d; logic [31:0] pc; logic [4:0] a3;} ent_t;
  typedef struct {bit v; logic [31:0] d; bit ev; logic [31:0] ed; logic [4:0] ea3; logic [1:0] eocc;} vec_t;
  ent_t q[$];
  ent_t shown;
  vec_t tv[11];

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc), .in_a3(in_a3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
    .out_a3(out_a3), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    shown.d = '0;
    shown.pc = 32'h3000;
    shown.a3 = '0;
    rdy_m = 1'b0;
  endtask

  function automatic bit exp_ready(input bit ordy, input bit stl);
    if (CAP == 2) return rdy_m;
    return q.size() == 0 || (ordy && !stl);
  endfunction

  task automatic check_outs();
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_data", out_data, shown.d);
    chk("out_pc", out_pc, shown.pc);
    chk("out_a3", out_a3, q.size() > 0 ? shown.a3 : 5'd0);
    chk("occ", occ, q.size());
  endtask

  // one clock: drive at negedge, check ready, update model at posedge, check outputs at next negedge
  task automatic step(input bit v, input logic [31:0] d, input logic [31:0] pc, input logic [4:0] a3,
                      input bit ordy, input bit stl, input bit fl);
    bit er, drn;
    ent_t e;
    in_valid = v; in_data = d; in_pc = pc; in_a3 = a3; out_ready = ordy; stall = stl; flush = fl;
    #1;
    er = exp_ready(ordy, stl);
    chk("in_ready", in_ready, er);
    last_acc = v && er;
    drn = q.size() > 0 && ordy && !stl;
    if (out_valid && ordy && !stl && out_data == 32'hDEAD_BEEF) dead_cnt++;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (last_acc) begin
        e.d = d; e.pc = pc; e.a3 = a3;
        q.push_back(e);
      end
    end
    if (q.size() > 0) shown = q[0];
    rdy_m = q.size() < 2;
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    bit pending;
    for (int i = 0; i < 11; i++) begin
      tv[i].v = !(i == 4 || i > 8);
      tv[i].d = (i < 4) ? i + 1 : i;
      tv[i].ev = tv[i].v;
      tv[i].ed = tv[i].v ? tv[i].d : (i == 4 ? 32'd4 : 32'd8);
      tv[i].ea3 = tv[i].v ? 5'd8 : 5'd0;
      tv[i].eocc = {1'b0, tv[i].v};
    end
    #1 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", out_pc, 32'h3000);
    chk("rst_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occ, 0);
    chk("rst_a3", out_a3, 0);
    // stream with one bubble
    for (int i = 0; i < 11; i++) begin
      step(tv[i].v, tv[i].d, 32'h4000 + tv[i].d * 4, 5'd8, 1, 0, 0);
      chk("tbl_valid", out_valid, tv[i].ev);
      chk("tbl_data", out_data, tv[i].ed);
      chk("tbl_a3", out_a3, tv[i].ea3);
      chk("tbl_occ", occ, tv[i].eocc);
    end
    // stall holds the slot
    step(1, 32'hDEAD_BEEF, 32'h5000, 5'd31, 0, 0, 0);
    pending = 1;
    for (int i = 0; i < 3; i++) begin
      step(pending, 32'h0000_CAFE, 32'h5004, 5'd9, 1, 1, 0);
      if (last_acc) pending = 0;
      chk("stall_data", out_data, 32'hDEAD_BEEF);
      chk("stall_a3", out_a3, 31);
      if (i == 0 && CAP == 2) begin
        chk("skid_occ", occ, 2);
        chk("skid_in_ready", in_ready, 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(pending, 32'h0000_CAFE, 32'h5004, 5'd9, 1, 0, 0);
      if (last_acc) pending = 0;
    end
    chk("dead_once", dead_cnt, 1);
    // flush with concurrent accept
    step(1, 32'h11, 32'h6000, 5'd3, 0, 1, 0);
    step(1, 32'h22, 32'h6004, 5'd4, 0, 1, 0);
    chk("full_occ", occ, CAP);
    step(1, 32'h55, 32'h6008, 5'd5, 1, 1, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_a3", out_a3, 0);
    chk("flush_occ", occ, 0);
    #1 chk("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      chk("flush_no55", out_data == 32'h55, 0);
    end
    // async reset mid-stream
    step(1, 32'h77, 32'h7000, 5'd7, 0, 1, 0);
    step(1, 32'h88, 32'h7004, 5'd8, 0, 1, 0);
    #2 reset = 1'b0;
    in_valid = 0; stall = 0;
    #1;
    model_reset();
    check_outs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
